line_writeback_unit: RTL and testbench

//  Reader/drain side of the 8-entry cache line data array. On a start request it walks

---
 rtl/line_writeback_if.sv | 31 +++
 rtl/line_writeback_unit.sv | 99 +++++++++
 tb/tb_line_writeback_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/line_writeback_if.sv
// Handshake bundle between the line writeback unit, its controller, the data array and the memory write port.
// The master side is the writeback unit; the slave side is everything around it.
interface line_writeback_if #(
    parameter int WIDTH  = 16,
    parameter int IDX_W  = 3,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDX_W-1:0]  arr_index;
    logic [WIDTH-1:0]  arr_rdata;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_last;
    logic              mem_ack;

    modport master (
        input  start, base_addr, arr_rdata, mem_ready, mem_ack,
        output busy, done, err, arr_index, mem_valid, mem_addr, mem_wdata, mem_last
    );

    modport slave (
        output start, base_addr, arr_rdata, mem_ready, mem_ack,
        input  busy, done, err, arr_index, mem_valid, mem_addr, mem_wdata, mem_last
    );
endinterface

// File: rtl/line_writeback_unit.sv
// Drains one cache line from the data array to memory, one beat per word, then waits for the write ack.
// Every output is registered; the array is read combinationally during the LOAD cycle of each beat.
module line_writeback_unit #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int IDX_W   = 3,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    line_writeback_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [TW-1:0]     TLIM     = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0]  ZWORD    = '0;
    localparam logic [ADDR_W-1:0] ZADDR    = '0;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_ACK, DONE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        count;
    logic [ADDR_W-IDX_W-1:0] base_hi;
    logic [TW-1:0]           timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            base_hi       <= '0;
            timer         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.arr_index <= '0;
            bus.mem_valid <= 1'b0;
            bus.mem_addr  <= ZADDR;
            bus.mem_wdata <= ZWORD;
            bus.mem_last  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_hi       <= bus.base_addr[ADDR_W-1:IDX_W];
                        count         <= '0;
                        bus.arr_index <= '0;
                        bus.busy      <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    bus.mem_wdata <= bus.arr_rdata;
                    bus.mem_addr  <= {base_hi, count};
                    bus.mem_last  <= (count == LAST_IDX);
                    bus.mem_valid <= 1'b1;
                    state         <= SEND;
                end
                SEND: begin
                    if (bus.mem_ready) begin
                        bus.mem_valid <= 1'b0;
                        bus.mem_last  <= 1'b0;
                        if (count == LAST_IDX) begin
                            // timer already counts the first WAIT_ACK cycle, so a missing
                            // ack lands done exactly TIMEOUT cycles after the last beat
                            timer <= TW'(1);
                            state <= WAIT_ACK;
                        end else begin
                            count         <= count + 1'b1;
                            bus.arr_index <= count + 1'b1;
                            state         <= LOAD;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (bus.mem_ack) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else if (timer == TLIM) begin
                        bus.done <= 1'b1;
                        bus.err  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    bus.busy      <= 1'b0;
                    bus.arr_index <= '0;
                    count         <= '0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_line_writeback_unit.sv
// Bench for line_writeback_unit: directed table of bursts, a reset-abort sequence and randomized bursts
// checked against an address/data/timing model derived from the line layout and ack rules.
module tb_line_writeback_unit;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_writeback_if #(.WIDTH(16), .IDX_W(3), .ADDR_W(16)) bus();

    line_writeback_unit #(
        .WIDTH(16), .DEPTH(DEPTH), .IDX_W(3), .ADDR_W(16), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic [15:0] arr [DEPTH];
    assign bus.arr_rdata = arr[bus.arr_index];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] base;
        int          stall_beat;
        int          stall_len;
        int          ack_k;
        bit          noise;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    // One full line writeback. ack_k<0 means memory never acks. abort_beat>=0 pulls reset
    // while that beat index is being offered and returns without the end-of-burst checks.
    task automatic run_burst(input logic [15:0] base, input int stall_beat, input int stall_len,
                             input int ack_k, input bit rnd, input bit noise, input int abort_beat,
                             input bit exp_err, input int exp_lat);
        logic [15:0] b_addr[$];
        logic [15:0] b_data[$];
        bit          b_last[$];
        int c0, last_cyc, done_cyc, ndone, stalled;
        bit derr, busy_ok, stable_ok, pend, fin, err_alone;
        logic [15:0] pa, pd;
        logic pl;
        last_cyc = -1; done_cyc = -1; ndone = 0; stalled = 0;
        derr = 0; busy_ok = 1; stable_ok = 1; pend = 0; fin = 0; err_alone = 0;
        pa = '0; pd = '0; pl = 0;

        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) arr[i] = rnd ? 16'($urandom) : 16'(16'hA000 + i);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.mem_ack   = 1'b0;
        bus.mem_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        c0 = cyc;
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_valid", 32'(bus.mem_valid), 32'd0);

        for (int n = 0; n < 400 && !fin; n++) begin
            @(posedge clk); #1;
            bus.start   = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            bus.mem_ack = (ack_k > 0 && last_cyc >= 0 && cyc == last_cyc + ack_k) ||
                          (rnd && last_cyc < 0 && $urandom_range(0, 5) == 0);
            if (rnd) bus.mem_ready = ($urandom_range(0, 3) != 0);
            else if (b_addr.size() == stall_beat && bus.mem_valid && stalled < stall_len) begin
                bus.mem_ready = 1'b0;
                stalled++;
            end else bus.mem_ready = 1'b1;

            @(negedge clk);
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (bus.err && !bus.done) err_alone = 1;
            if (pend && (bus.mem_valid !== 1'b1 || bus.mem_addr !== pa ||
                         bus.mem_wdata !== pd || bus.mem_last !== pl)) stable_ok = 0;
            if (abort_beat >= 0 && b_addr.size() == abort_beat && bus.mem_valid) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_valid", 32'(bus.mem_valid), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_addr", 32'(bus.mem_addr), 32'd0);
                chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
                chk("rst_index", 32'(bus.arr_index), 32'd0);
                bus.start = 1'b0; bus.mem_ack = 1'b0;
                return;
            end
            if (bus.mem_valid && bus.mem_ready) begin
                b_addr.push_back(bus.mem_addr);
                b_data.push_back(bus.mem_wdata);
                b_last.push_back(bus.mem_last);
                if (b_addr.size() == DEPTH) last_cyc = cyc;
            end
            pend = bus.mem_valid && !bus.mem_ready;
            pa = bus.mem_addr; pd = bus.mem_wdata; pl = bus.mem_last;
            if (bus.done) begin
                ndone++; derr = bus.err; done_cyc = cyc; fin = 1;
            end
        end
        bus.start = 1'b0; bus.mem_ack = 1'b0;

        chk("beats", 32'(b_addr.size()), 32'(DEPTH));
        for (int i = 0; i < b_addr.size(); i++) begin
            chk("addr", 32'(b_addr[i]), 32'(16'((base & 16'hFFF8) + 16'(i))));
            chk("data", 32'(b_data[i]), 32'(arr[i]));
            chk("last", 32'(b_last[i]), 32'(i == DEPTH - 1));
        end
        chk("done_count", 32'(ndone), 32'd1);
        chk("err", 32'(derr), 32'(exp_err));
        chk("err_without_done", 32'(err_alone), 32'd0);
        chk("ack_gap", 32'(done_cyc - last_cyc), 32'(ack_k > 0 ? ack_k + 1 : TIMEOUT));
        if (exp_lat > 0) chk("latency", 32'(done_cyc - c0), 32'(exp_lat));
        chk("busy_hold", 32'(busy_ok), 32'd1);
        chk("beat_stable", 32'(stable_ok), 32'd1);
    endtask

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.mem_ready = 1'b0; bus.mem_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) arr[i] = '0;

        // base, stall_beat, stall_len, ack_k, noise, exp_err, exp_lat (start to done)
        vt[0] = '{16'h0120, -1, 0,  3, 1'b0, 1'b0, 20};
        vt[1] = '{16'h0120,  2, 5,  3, 1'b0, 1'b0, 25};
        vt[2] = '{16'h0120, -1, 0,  5, 1'b1, 1'b0, 22};
        vt[3] = '{16'h0120, -1, 0, -1, 1'b0, 1'b1, 32};
        vt[4] = '{16'h0125, -1, 0,  1, 1'b0, 1'b0, 18};
        vt[5] = '{16'hFFF8, -1, 0,  2, 1'b0, 1'b0, 19};
        vt[6] = '{16'hFFFF, -1, 0, 15, 1'b0, 1'b0, 32};

        #12;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_err", 32'(bus.err), 32'd0);
        chk("reset_valid", 32'(bus.mem_valid), 32'd0);
        chk("reset_last", 32'(bus.mem_last), 32'd0);
        chk("reset_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("reset_index", 32'(bus.arr_index), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int v = 0; v < 7; v++)
            run_burst(vt[v].base, vt[v].stall_beat, vt[v].stall_len, vt[v].ack_k, 1'b0,
                      vt[v].noise, -1, vt[v].exp_err, vt[v].exp_lat);

        // reset while the fourth beat is offered, then a clean burst from a new base
        run_burst(16'h0120, -1, 0, 3, 1'b0, 1'b0, 3, 1'b0, -1);
        @(negedge clk);
        chk("rst_hold_valid", 32'(bus.mem_valid), 32'd0);
        rst_n = 1'b1;
        run_burst(16'h0340, -1, 0, 2, 1'b0, 1'b0, -1, 1'b0, 19);

        for (int r = 0; r < 25; r++) begin
            int k;
            k = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, TIMEOUT - 1));
            run_burst(16'($urandom), -1, 0, k, 1'b1, ($urandom_range(0, 1) == 1), -1, (k < 0), -1);
        end

        @(negedge clk);
        chk("final_busy", 32'(bus.busy), 32'd0);
        chk("final_done", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
